// File: rtl/mem_access_ctrl_if.sv
// Control-unit / memory handshake bundle for mem_access_ctrl.
// The sequencer connects through the slave modport and the control-unit side through master.
interface mem_access_ctrl_if;
    logic       rd_req;
    logic       wr_req;
    logic       mem_ready;
    logic       MARin;
    logic       MDRin;
    logic       read;
    logic       mem_read;
    logic       mem_write;
    logic [1:0] bus_phase;
    logic       busy;
    logic       done;
    logic       err;

    modport slave (
        input  rd_req, wr_req, mem_ready,
        output MARin, MDRin, read, mem_read, mem_write, bus_phase, busy, done, err
    );

    modport master (
        output rd_req, wr_req, mem_ready,
        input  MARin, MDRin, read, mem_read, mem_write, bus_phase, busy, done, err
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// MiniSRC memory-side sequencer: steps MARin, the MDR load/mux, the memory strobes and done.
// Define MEM_TIMEOUT_EN to bound the access wait and flag an expired wait on err.
module mem_access_ctrl #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_WIDTH      = 5
) (
    input  logic             clock,
    input  logic             clear_n,
    mem_access_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE, MAR_R, MAR_W, DATA_W, ACC_R, ACC_W, CAPT, DONE
    } state_t;

    state_t state, state_nxt;
    logic   timeout_hit;

    if ((2 ** CNT_WIDTH) <= TIMEOUT_CYCLES) begin : g_cnt_width_check
        $error("CNT_WIDTH too narrow to count to TIMEOUT_CYCLES");
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

`ifdef MEM_TIMEOUT_EN
    logic                 in_acc;
    logic [CNT_WIDTH-1:0] wait_cnt;
    logic                 err_q;

    assign in_acc      = (state == ACC_R) || (state == ACC_W);
    assign timeout_hit = in_acc && !bus.mem_ready &&
                         (wait_cnt == CNT_WIDTH'(TIMEOUT_CYCLES - 1));

    // The counter rests at zero outside the access states, so every entry starts from zero.
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            wait_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            err_q <= timeout_hit;
            if (!in_acc)
                wait_cnt <= '0;
            else if (!bus.mem_ready)
                wait_cnt <= wait_cnt + 1'b1;
        end
    end

    assign bus.err = err_q;
`else
    assign timeout_hit = 1'b0;
    assign bus.err     = 1'b0;
`endif

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (bus.rd_req)
                    state_nxt = MAR_R;
                else if (bus.wr_req)
                    state_nxt = MAR_W;
            end
            MAR_R:  state_nxt = ACC_R;
            MAR_W:  state_nxt = DATA_W;
            DATA_W: state_nxt = ACC_W;
            ACC_R: begin
                if (bus.mem_ready)
                    state_nxt = CAPT;
                else if (timeout_hit)
                    state_nxt = DONE;
            end
            ACC_W: begin
                if (bus.mem_ready || timeout_hit)
                    state_nxt = DONE;
            end
            CAPT:    state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Moore decode: outputs depend on the registered state only.
    always_comb begin
        bus.MARin     = 1'b0;
        bus.MDRin     = 1'b0;
        bus.read      = 1'b0;
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        bus.bus_phase = 2'b00;
        case (state)
            MAR_R, MAR_W: begin
                bus.MARin     = 1'b1;
                bus.bus_phase = 2'b01;
            end
            DATA_W: begin
                bus.MDRin     = 1'b1;
                bus.bus_phase = 2'b10;
            end
            ACC_R: begin
                bus.mem_read = 1'b1;
                bus.read     = 1'b1;
            end
            CAPT: begin
                bus.mem_read = 1'b1;
                bus.read     = 1'b1;
                bus.MDRin    = 1'b1;
            end
            ACC_W:   bus.mem_write = 1'b1;
            default: ;
        endcase
        bus.busy = (state != IDLE);
        bus.done = (state == DONE);
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: a transaction-level model expands each accepted request into its
// expected per-cycle output sequence; directed scenarios pin latencies with literal values.
module tb_mem_access_ctrl;

    localparam int T_CYC = 4;
`ifdef MEM_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    typedef struct packed {
        logic       MARin;
        logic       MDRin;
        logic       read;
        logic       mem_read;
        logic       mem_write;
        logic [1:0] bus_phase;
        logic       busy;
        logic       done;
        logic       err;
    } outs_t;

    typedef struct packed {
        outs_t o;
        logic  rdy;
    } slot_t;

    localparam outs_t V_IDLE  = '0;
    localparam outs_t V_MAR   = '{MARin:1'b1, bus_phase:2'b01, busy:1'b1, default:'0};
    localparam outs_t V_DATAW = '{MDRin:1'b1, bus_phase:2'b10, busy:1'b1, default:'0};
    localparam outs_t V_ACCR  = '{mem_read:1'b1, read:1'b1, busy:1'b1, default:'0};
    localparam outs_t V_CAPT  = '{mem_read:1'b1, read:1'b1, MDRin:1'b1, busy:1'b1, default:'0};
    localparam outs_t V_ACCW  = '{mem_write:1'b1, busy:1'b1, default:'0};
    localparam outs_t V_DONE  = '{done:1'b1, busy:1'b1, default:'0};
    localparam outs_t V_DERR  = '{done:1'b1, busy:1'b1, err:1'b1, default:'0};

    localparam int F_MAR = 0, F_MDR = 1, F_RD = 2, F_MRD = 3, F_MWR = 4;
    localparam int F_P01 = 5, F_P10 = 6, F_BUSY = 7, F_DONE = 8, F_ERR = 9;

    logic clock   = 1'b0;
    logic clear_n = 1'b0;

    mem_access_ctrl_if ifc();

    mem_access_ctrl #(
        .TIMEOUT_CYCLES(T_CYC),
        .CNT_WIDTH     (3)
    ) dut (
        .clock  (clock),
        .clear_n(clear_n),
        .bus    (ifc)
    );

    always #5 clock = ~clock;

    slot_t q[$];
    outs_t exp_cur   = V_IDLE;
    bit    exp_valid = 1'b1;
    outs_t obs[0:31];
    int    n_checks  = 0;
    int    n_pass    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s @%0t: got 0x%0h, want 0x%0h", name, $time, act, exp);
    endtask

    function automatic outs_t dut_outs();
        outs_t o;
        o.MARin     = ifc.MARin;
        o.MDRin     = ifc.MDRin;
        o.read      = ifc.read;
        o.mem_read  = ifc.mem_read;
        o.mem_write = ifc.mem_write;
        o.bus_phase = ifc.bus_phase;
        o.busy      = ifc.busy;
        o.done      = ifc.done;
        o.err       = ifc.err;
        return o;
    endfunction

    always @(negedge clock)
        if (exp_valid)
            check("cycle_outs", 32'(dut_outs()), 32'(exp_cur));

    task automatic push_slot(input outs_t v, input logic r);
        q.push_back('{o: v, rdy: r});
    endtask

    // One accepted access expands into: MAR, [DATA_W], waits+1 ACC cycles, [CAPT], DONE.
    task automatic push_plan(input bit is_rd, input int waits);
        bit tout;
        int acc_n;
        tout  = TO_EN && (waits >= T_CYC);
        acc_n = tout ? T_CYC : waits + 1;
        push_slot(V_MAR, 1'($urandom_range(0, 1)));
        if (!is_rd)
            push_slot(V_DATAW, 1'($urandom_range(0, 1)));
        for (int i = 0; i < acc_n; i++)
            push_slot(is_rd ? V_ACCR : V_ACCW, 1'(!tout && (i == acc_n - 1)));
        if (is_rd && !tout)
            push_slot(V_CAPT, 1'($urandom_range(0, 1)));
        push_slot(tout ? V_DERR : V_DONE, 1'($urandom_range(0, 1)));
    endtask

    // Advance one clock; set the expectation for the new state and drive inputs for the next edge.
    task automatic cycle(input logic rq, input logic wq, input int waits);
        slot_t cur;
        bit    idle_now;
        @(posedge clock);
        #1;
        idle_now = (q.size() == 0);
        if (idle_now) begin
            cur.o   = V_IDLE;
            cur.rdy = 1'($urandom_range(0, 1));
        end else begin
            cur = q.pop_front();
        end
        exp_cur       = cur.o;
        exp_valid     = 1'b1;
        ifc.mem_ready = cur.rdy;
        ifc.rd_req    = rq;
        ifc.wr_req    = wq;
        if (idle_now) begin
            if (rq)
                push_plan(1'b1, waits);
            else if (wq)
                push_plan(1'b0, waits);
        end
    endtask

    task automatic drain();
        while (q.size() != 0)
            cycle(1'b0, 1'b0, 0);
    endtask

    task automatic observe(input int n, input logic rq, input logic wq);
        for (int k = 0; k < 32; k++)
            obs[k] = '0;
        for (int k = 1; k <= n; k++) begin
            cycle(rq, wq, 0);
            obs[k] = dut_outs();
        end
    endtask

    function automatic logic [31:0] trace(input int f);
        logic [31:0] m;
        m = '0;
        for (int k = 1; k < 32; k++) begin
            case (f)
                F_MAR:   m[k] = obs[k].MARin;
                F_MDR:   m[k] = obs[k].MDRin;
                F_RD:    m[k] = obs[k].read;
                F_MRD:   m[k] = obs[k].mem_read;
                F_MWR:   m[k] = obs[k].mem_write;
                F_P01:   m[k] = (obs[k].bus_phase == 2'b01);
                F_P10:   m[k] = (obs[k].bus_phase == 2'b10);
                F_BUSY:  m[k] = obs[k].busy;
                F_DONE:  m[k] = obs[k].done;
                default: m[k] = obs[k].err;
            endcase
        end
        return m;
    endfunction

    task automatic directed_read(input string tag);
        drain();
        cycle(1'b1, 1'b0, 0);
        observe(7, 1'b0, 1'b0);
        check({tag, "_marin"},   trace(F_MAR),  32'h0000_0002);
        check({tag, "_memread"}, trace(F_MRD),  32'h0000_000C);
        check({tag, "_mdrin"},   trace(F_MDR),  32'h0000_0008);
        check({tag, "_readsel"}, trace(F_RD),   32'h0000_000C);
        check({tag, "_done"},    trace(F_DONE), 32'h0000_0010);
        check({tag, "_busy"},    trace(F_BUSY), 32'h0000_001E);
        check({tag, "_memwr"},   trace(F_MWR),  32'h0000_0000);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [31:0] dmask;
        int          waits;
        ifc.rd_req    = 1'b0;
        ifc.wr_req    = 1'b0;
        ifc.mem_ready = 1'b0;

        repeat (3) @(posedge clock);
        #1;
        check("reset_outs", 32'(dut_outs()), 32'(V_IDLE));
        clear_n = 1'b1;

        directed_read("read0");

        drain();
        cycle(1'b0, 1'b1, 2);
        observe(9, 1'b0, 1'b0);
        check("wr_marin",  trace(F_MAR),  32'h0000_0002);
        check("wr_ph01",   trace(F_P01),  32'h0000_0002);
        check("wr_ph10",   trace(F_P10),  32'h0000_0004);
        check("wr_memwr",  trace(F_MWR),  32'h0000_0038);
        check("wr_done",   trace(F_DONE), 32'h0000_0040);
        check("wr_read",   trace(F_RD),   32'h0000_0000);

        drain();
        cycle(1'b1, 1'b1, 0);
        observe(7, 1'b0, 1'b0);
        check("both_memwr", trace(F_MWR),  32'h0000_0000);
        check("both_memrd", trace(F_MRD),  32'h0000_000C);
        check("both_done",  trace(F_DONE), 32'h0000_0010);

        drain();
        cycle(1'b1, 1'b0, 10);
        repeat (3) cycle(1'b0, 1'b0, 0);
        check("mid_memrd", 32'(ifc.mem_read), 32'd1);
        #2;
        exp_cur    = V_IDLE;
        clear_n    = 1'b0;
        ifc.rd_req = 1'b0;
        ifc.wr_req = 1'b0;
        #1;
        check("mid_rst_outs", 32'(dut_outs()), 32'(V_IDLE));
        q.delete();
        @(posedge clock);
        #3;
        clear_n = 1'b1;
        directed_read("after_rst");

        drain();
        cycle(1'b1, 1'b0, 0);
        observe(20, 1'b1, 1'b0);
        dmask = trace(F_DONE);
        check("b2b_done",     dmask, 32'h0008_4210);
        check("b2b_adjacent", dmask & (dmask >> 1), 32'h0);

        drain();
        cycle(1'b1, 1'b0, 20);
        observe(30, 1'b0, 1'b0);
        check("long_memrd", $countones(trace(F_MRD)), TO_EN ? 4 : 22);
        check("long_mdrin", $countones(trace(F_MDR)), TO_EN ? 0 : 1);
        check("long_done",  trace(F_DONE), TO_EN ? 32'h40 : 32'h0100_0000);
        check("long_err",   trace(F_ERR),  TO_EN ? 32'h40 : 32'h0);

        drain();
        cycle(1'b1, 1'b0, 3);
        observe(10, 1'b0, 1'b0);
        check("term_memrd", $countones(trace(F_MRD)), 5);
        check("term_mdrin", trace(F_MDR),  32'h0000_0040);
        check("term_done",  trace(F_DONE), 32'h0000_0080);
        check("term_err",   trace(F_ERR),  32'h0000_0000);

        for (int i = 0; i < 400; i++) begin
            waits = ($urandom_range(0, 9) < 7) ? int'($urandom_range(0, 2))
                                                : int'($urandom_range(3, 8));
            cycle(1'($urandom_range(0, 9) < 3), 1'($urandom_range(0, 9) < 3), waits);
        end
        drain();
        cycle(1'b0, 1'b0, 0);
        cycle(1'b0, 1'b0, 0);
        @(negedge clock);
        #1;
        exp_valid = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
